// File: rtl/shift_rows_pipe_if.sv
// Handshake bundle for shift_rows_pipe: input transfer channel, output result channel, busy flag.
interface shift_rows_pipe_if #(
  parameter int unsigned NB = 4
);
  localparam int unsigned W = 32 * NB;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_state;
  logic         in_inv;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_state;
  logic         busy;

  modport master (
    output in_valid, in_state, in_inv, out_ready,
    input  in_ready, out_valid, out_state, busy
  );

  modport slave (
    input  in_valid, in_state, in_inv, out_ready,
    output in_ready, out_valid, out_state, busy
  );
endinterface

// File: rtl/shift_rows_pipe.sv
// AES (Inv)ShiftRows permutation feeding a 2-entry main+skid output FIFO, 1-cycle latency.
// Macro SHIFT_ROWS_INV_EN compiles in the inverse datapath selected per transfer by in_inv.
module shift_rows_pipe #(
  parameter int unsigned NB = 4
) (
  input logic           clk,
  input logic           rst_n,
  shift_rows_pipe_if.slave bus
);
  localparam int unsigned W = 32 * NB;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : gBadNb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end

  logic [W-1:0] fwdState;
  logic [W-1:0] permState;

  // Byte (r,c) sits at bits [W-1-8*(4c+r) -: 8]; sources are fixed per byte, so this is pure wiring.
  for (genvar c = 0; c < NB; c++) begin : gCol
    for (genvar r = 0; r < 4; r++) begin : gRow
      localparam int unsigned Off    = (NB == 8 && r >= 2) ? r + 1 : r;
      localparam int unsigned FwdSrc = (c + Off) % NB;
      assign fwdState[W-1-8*(4*c+r) -: 8] = bus.in_state[W-1-8*(4*FwdSrc+r) -: 8];
    end
  end

`ifdef SHIFT_ROWS_INV_EN
  logic [W-1:0] invState;

  for (genvar c = 0; c < NB; c++) begin : gInvCol
    for (genvar r = 0; r < 4; r++) begin : gInvRow
      localparam int unsigned Off    = (NB == 8 && r >= 2) ? r + 1 : r;
      localparam int unsigned InvSrc = (c + NB - Off) % NB;
      assign invState[W-1-8*(4*c+r) -: 8] = bus.in_state[W-1-8*(4*InvSrc+r) -: 8];
    end
  end

  assign permState = bus.in_inv ? invState : fwdState;
`else
  logic unusedInv;

  assign unusedInv = bus.in_inv;
  assign permState = fwdState;
`endif

  logic [1:0]   countQ, countD;
  logic [W-1:0] mainQ, mainD;
  logic [W-1:0] skidQ, skidD;
  logic         inReadyQ;
  logic         outValidQ;
  logic         busyQ;
  logic         accept;
  logic         consume;

  assign accept  = bus.in_valid && inReadyQ;
  assign consume = outValidQ && bus.out_ready;

  // Main entry always holds the oldest result; skid only fills when main is stalled.
  always_comb begin
    countD = countQ;
    mainD  = mainQ;
    skidD  = skidQ;
    case (countQ)
      2'd0: begin
        if (accept) begin
          mainD  = permState;
          countD = 2'd1;
        end
      end
      2'd1: begin
        if (accept && consume) begin
          mainD = permState;
        end else if (accept) begin
          skidD  = permState;
          countD = 2'd2;
        end else if (consume) begin
          countD = 2'd0;
        end
      end
      2'd2: begin
        if (consume) begin
          mainD  = skidQ;
          countD = 2'd1;
        end
      end
      default: countD = 2'd0;
    endcase
  end

  // Flags are registered from next occupancy so in_ready never sees out_ready combinationally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      countQ    <= 2'd0;
      mainQ     <= '0;
      skidQ     <= '0;
      inReadyQ  <= 1'b0;
      outValidQ <= 1'b0;
      busyQ     <= 1'b0;
    end else begin
      countQ    <= countD;
      mainQ     <= mainD;
      skidQ     <= skidD;
      inReadyQ  <= (countD != 2'd2);
      outValidQ <= (countD != 2'd0);
      busyQ     <= (countD != 2'd0);
    end
  end

  assign bus.in_ready  = inReadyQ;
  assign bus.out_valid = outValidQ;
  assign bus.out_state = mainQ;
  assign bus.busy      = busyQ;
endmodule

// File: tb/tb_shift_rows_pipe.sv
// Directed bench for shift_rows_pipe: NB=4 and NB=8 instances, backpressure, streaming, reset.
module tb_shift_rows_pipe;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  shift_rows_pipe_if #(.NB(4)) bus4 ();
  shift_rows_pipe_if #(.NB(8)) bus8 ();

  shift_rows_pipe #(.NB(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  shift_rows_pipe #(.NB(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: walk every output byte and look up its source column.
  function automatic logic [127:0] refShift(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
`ifdef SHIFT_ROWS_INV_EN
        src = inv ? (c + 4 - r) % 4 : (c + r) % 4;
`else
        src = (c + r) % 4;
        if (inv) src = (c + r) % 4;
`endif
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*src+r) -: 8];
      end
    end
    return o;
  endfunction

  localparam logic [127:0] IdState  = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] FwdId    = 128'h00050A0F04090E03080D02070C01060B;
  localparam logic [127:0] InvId    = 128'h000D0A0704010E0B0805020F0C090603;
  localparam logic [255:0] Id8      = 256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;
  localparam logic [255:0] Fwd8     = 256'h0005_0E13_0409_1217_080D_161B_0C11_1A1F_1015_1E03_1419_0207_181D_060B_1C01_0A0F;
  localparam logic [127:0] StA      = 128'h11223344_55667788_99AABBCC_DDEEFF00;
  localparam logic [127:0] StB      = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;
  localparam logic [127:0] StC      = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;

  initial begin
    logic [127:0] s;
    logic [127:0] exp;
    logic         inv;
    logic [255:0] o8;
    logic [7:0]   b;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_state = '0; bus4.in_inv = 1'b0; bus4.out_ready = 1'b0;
    bus8.in_valid = 1'b0; bus8.in_state = '0; bus8.in_inv = 1'b0; bus8.out_ready = 1'b0;

    // Reset state
    step();
    chk("rst_in_ready", 256'(bus4.in_ready), 256'(0));
    chk("rst_out_valid", 256'(bus4.out_valid), 256'(0));
    chk("rst_busy", 256'(bus4.busy), 256'(0));
    chk("rst_out_state", 256'(bus4.out_state), 256'(0));
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", 256'(bus4.in_ready), 256'(1));
    chk("post_rst_out_valid", 256'(bus4.out_valid), 256'(0));

    // Forward permutation, 1-cycle latency
    bus4.in_valid = 1'b1; bus4.in_state = IdState; bus4.in_inv = 1'b0; bus4.out_ready = 1'b1;
    step();
    bus4.in_valid = 1'b0;
    chk("fwd_valid", 256'(bus4.out_valid), 256'(1));
    chk("fwd_state", 256'(bus4.out_state), 256'(FwdId));
    step();
    chk("fwd_drained", 256'(bus4.out_valid), 256'(0));

`ifdef SHIFT_ROWS_INV_EN
    bus4.in_valid = 1'b1; bus4.in_state = FwdId; bus4.in_inv = 1'b1;
    step();
    bus4.in_valid = 1'b0;
    chk("inv_roundtrip", 256'(bus4.out_state), 256'(IdState));
    bus4.in_valid = 1'b1; bus4.in_state = IdState; bus4.in_inv = 1'b1;
    step();
    bus4.in_valid = 1'b0;
    chk("inv_identity", 256'(bus4.out_state), 256'(InvId));
`else
    bus4.in_valid = 1'b1; bus4.in_state = IdState; bus4.in_inv = 1'b1;
    step();
    bus4.in_valid = 1'b0;
    chk("inv_ignored", 256'(bus4.out_state), 256'(FwdId));
`endif
    bus4.in_inv = 1'b0;
    step();

    // Backpressure: 3 offered, 2 accepted, order and stability preserved
    bus4.out_ready = 1'b0;
    bus4.in_valid = 1'b1; bus4.in_state = StA;
    step();
    bus4.in_state = StB;
    step();
    chk("bp_full_ready", 256'(bus4.in_ready), 256'(0));
    chk("bp_hold_a0", 256'(bus4.out_state), 256'(refShift(StA, 1'b0)));
    bus4.in_state = StC;
    step();
    chk("bp_still_full", 256'(bus4.in_ready), 256'(0));
    chk("bp_hold_a1", 256'(bus4.out_state), 256'(refShift(StA, 1'b0)));
    chk("bp_busy", 256'(bus4.busy), 256'(1));
    bus4.out_ready = 1'b1;
    step();
    chk("bp_out_b", 256'(bus4.out_state), 256'(refShift(StB, 1'b0)));
    chk("bp_ready_again", 256'(bus4.in_ready), 256'(1));
    step();
    bus4.in_valid = 1'b0;
    chk("bp_out_c", 256'(bus4.out_state), 256'(refShift(StC, 1'b0)));
    chk("bp_c_valid", 256'(bus4.out_valid), 256'(1));
    step();
    chk("bp_empty", 256'(bus4.out_valid), 256'(0));

    // NB=8 forward
    bus8.in_valid = 1'b1; bus8.in_state = Id8; bus8.out_ready = 1'b1;
    step();
    bus8.in_valid = 1'b0;
    chk("nb8_valid", 256'(bus8.out_valid), 256'(1));
    chk("nb8_state", bus8.out_state, Fwd8);
    o8 = bus8.out_state;
    b = o8[255-8*3 -: 8];
    chk("nb8_r3c0", 256'(b), 256'(8'h13));
    b = o8[255-8*2 -: 8];
    chk("nb8_r2c0", 256'(b), 256'(8'h0E));
    step();

    // Streaming: 100 back-to-back transfers, mixed mode
    bus4.out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      s   = {$urandom, $urandom, $urandom, $urandom};
      inv = 1'($urandom_range(0, 1));
      exp = refShift(s, inv);
      bus4.in_valid = 1'b1; bus4.in_state = s; bus4.in_inv = inv;
      step();
      chk("stream_flags", 256'({bus4.out_valid, bus4.in_ready}), 256'(2'b11));
      chk("stream_data", 256'(bus4.out_state), 256'(exp));
    end
    bus4.in_valid = 1'b0; bus4.in_inv = 1'b0;
    step();
    chk("stream_drained", 256'(bus4.out_valid), 256'(0));

    // Reset with FIFO full
    bus4.out_ready = 1'b0;
    bus4.in_valid = 1'b1; bus4.in_state = StA;
    step();
    bus4.in_state = StB;
    step();
    bus4.in_valid = 1'b0;
    chk("mid_full", 256'(bus4.in_ready), 256'(0));
    rst_n = 1'b0;
    step();
    chk("mid_rst_valid", 256'(bus4.out_valid), 256'(0));
    chk("mid_rst_busy", 256'(bus4.busy), 256'(0));
    chk("mid_rst_state", 256'(bus4.out_state), 256'(0));
    chk("mid_rst_ready", 256'(bus4.in_ready), 256'(0));
    rst_n = 1'b1;
    bus4.out_ready = 1'b1;
    step();
    chk("mid_rel_ready", 256'(bus4.in_ready), 256'(1));
    chk("mid_rel_valid", 256'(bus4.out_valid), 256'(0));
    step();
    step();
    chk("mid_no_stale", 256'({bus4.out_valid, bus4.busy}), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
